// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among R requesters.
// Ports: Clock/Reset; Req, ReqMultiplicand, ReqMultiplier from requesters;
// Grant, Done, Result, Error back to them; MulStart, MulMultiplicand,
// MulMultiplier to the multiplier; MulProduct, MulReady from it.
module mul_share_arbiter #(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [R-1:0]     Req,
    input  logic [R*N-1:0]   ReqMultiplicand,
    input  logic [R*N-1:0]   ReqMultiplier,
    output logic [R-1:0]     Grant,
    output logic [R-1:0]     Done,
    output logic [2*N-1:0]   Result,
    output logic             Error,
    output logic             MulStart,
    output logic [N-1:0]     MulMultiplicand,
    output logic [N-1:0]     MulMultiplier,
    input  logic [2*N-1:0]   MulProduct,
    input  logic             MulReady
);

    localparam int TMO = 2 * N + 4;
    localparam int CW  = $clog2(TMO + 1);
    localparam int IW  = $clog2(R);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [R-1:0]    grant_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  result_q;
    logic            error_q;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            ready_ok;
    logic            tmo;

    // First requesting index after the last owner, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= R; i++) begin
            int j;
            j = (int'(last) + i) % R;
            if (!pick_found && Req[j]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

    // Ready in the first WAIT cycle may be left over from the previous
    // operation, so it only counts once the counter has advanced.
    assign ready_ok = MulReady && (cnt != '0);
    // Fires on the last of TMO wait cycles; ready wins if both apply.
    assign tmo      = (cnt == CW'(TMO - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ready_ok || tmo) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            owner    <= '0;
            last     <= IW'(R - 1);
            grant_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        owner   <= pick_idx;
                        grant_q <= {{(R-1){1'b0}}, 1'b1} << pick_idx;
                        a_q     <= ReqMultiplicand[pick_idx*N +: N];
                        b_q     <= ReqMultiplier[pick_idx*N +: N];
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (ready_ok) begin
                        result_q <= MulProduct;
                        error_q  <= 1'b0;
                    end else if (tmo) begin
                        result_q <= '0;
                        error_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    last     <= owner;
                    grant_q  <= '0;
                    result_q <= '0;
                    error_q  <= 1'b0;
                end
            endcase
        end
    end

    // Result/Error registers are cleared on leaving DONE, so they are
    // only nonzero while Done pulses.
    always_comb begin
        Grant           = grant_q;
        Done            = (state == S_DONE) ? grant_q : '0;
        Result          = result_q;
        Error           = error_q;
        MulStart        = (state == S_ISSUE);
        MulMultiplicand = a_q;
        MulMultiplier   = b_q;
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with a behavioural
// sequential multiplier model of configurable latency.
module tb_mul_share_arbiter;

    localparam int N = 4;
    localparam int R = 4;

    logic             Clock = 1'b0;
    logic             Reset;
    logic [R-1:0]     Req;
    logic [R*N-1:0]   ReqMultiplicand;
    logic [R*N-1:0]   ReqMultiplier;
    logic [R-1:0]     Grant;
    logic [R-1:0]     Done;
    logic [2*N-1:0]   Result;
    logic             Error;
    logic             MulStart;
    logic [N-1:0]     MulMultiplicand;
    logic [N-1:0]     MulMultiplier;
    logic [2*N-1:0]   MulProduct;
    logic             MulReady;

    int passed = 0;
    int total  = 0;

    int lat;
    logic dead;
    logic hold_stale;
    int start_total;
    logic m_busy;
    int m_cnt;
    logic [2*N-1:0] m_res;

    always #5 Clock = ~Clock;

    mul_share_arbiter #(.N(N), .R(R)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Req             (Req),
        .ReqMultiplicand (ReqMultiplicand),
        .ReqMultiplier   (ReqMultiplier),
        .Grant           (Grant),
        .Done            (Done),
        .Result          (Result),
        .Error           (Error),
        .MulStart        (MulStart),
        .MulMultiplicand (MulMultiplicand),
        .MulMultiplier   (MulMultiplier),
        .MulProduct      (MulProduct),
        .MulReady        (MulReady)
    );

    // Multiplier model: Ready rises lat cycles after the start edge and
    // stays high until the next start (or, in stale mode, until one
    // cycle after it).
    always @(posedge Clock) begin
        if (Reset) begin
            MulReady    <= 1'b0;
            MulProduct  <= '0;
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            start_total <= 0;
        end else if (MulStart) begin
            start_total <= start_total + 1;
            m_busy      <= 1'b1;
            m_cnt       <= 0;
            m_res       <= MulMultiplicand * MulMultiplier;
            if (!hold_stale) MulReady <= 1'b0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (!dead && (m_cnt + 1 == lat)) begin
                MulReady   <= 1'b1;
                MulProduct <= m_res;
                m_busy     <= 1'b0;
            end else begin
                MulReady <= 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic wait_done(input logic [R-1:0] ed,
                             input logic [2*N-1:0] er,
                             input logic ee, input int edges,
                             input string tag);
        int n;
        int base;
        base = start_total;
        n = 0;
        do begin
            step();
            n++;
        end while (Done == '0 && n < 60);
        chk(32'(Done), 32'(ed), {tag, " done"});
        chk(32'(Result), 32'(er), {tag, " result"});
        chk(32'(Error), 32'(ee), {tag, " error"});
        chk(n, edges, {tag, " latency"});
        chk(start_total - base, 1, {tag, " starts"});
    endtask

    initial begin
        int seen;
        Reset = 1'b1;
        Req = '0;
        ReqMultiplicand = '0;
        ReqMultiplier = '0;
        lat = 1;
        dead = 1'b0;
        hold_stale = 1'b0;
        step();
        do_reset();

        chk(32'(Grant), 0, "rst grant");
        chk(32'(Done), 0, "rst done");
        chk(32'(Result), 0, "rst result");
        chk(32'(Error), 0, "rst error");
        chk(32'(MulStart), 0, "rst start");
        chk(32'(MulMultiplicand), 0, "rst mula");
        chk(32'(MulMultiplier), 0, "rst mulb");

        // single request; operand change and Req drop after grant
        Req = 4'b0001;
        ReqMultiplicand = 16'h0003;
        ReqMultiplier = 16'h0005;
        step();
        chk(32'(Grant), 32'h1, "single grant");
        chk(32'(MulStart), 1, "single start");
        chk(32'(MulMultiplicand), 3, "single mula");
        chk(32'(MulMultiplier), 5, "single mulb");
        Req = '0;
        ReqMultiplicand = 16'h0007;
        wait_done(4'b0001, 8'd15, 1'b0, 3, "single");
        chk(32'(Grant), 32'h1, "single grant in done");
        chk(32'(MulMultiplicand), 3, "single mula held");
        step();
        chk(32'(Grant), 0, "single grant cleared");
        chk(32'(Done), 0, "single done pulse");
        chk(32'(Result), 0, "single result cleared");

        // extremes
        Req = 4'b0001;
        ReqMultiplicand = 16'h000F;
        ReqMultiplier = 16'h000F;
        wait_done(4'b0001, 8'hE1, 1'b0, 4, "ff");
        Req = '0;
        step();
        Req = 4'b0001;
        ReqMultiplicand = 16'h0000;
        ReqMultiplier = 16'h0009;
        wait_done(4'b0001, 8'h00, 1'b0, 4, "zero");
        Req = '0;
        step();

        // contention
        do_reset();
        Req = 4'b1111;
        ReqMultiplicand = 16'h4321;
        ReqMultiplier = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            int k;
            k = i % 4;
            wait_done(4'b0001 << k, 8'((k + 1) * 15), 1'b0,
                      (i == 0) ? 4 : 5, "rr");
        end
        Req = '0;
        step();

        // timeout, then a normal request
        do_reset();
        dead = 1'b1;
        Req = 4'b0010;
        ReqMultiplicand = 16'h0050;
        ReqMultiplier = 16'h0030;
        wait_done(4'b0010, 8'h00, 1'b1, 14, "tmo");
        Req = '0;
        dead = 1'b0;
        step();
        Req = 4'b1000;
        ReqMultiplicand = 16'h6000;
        ReqMultiplier = 16'h7000;
        wait_done(4'b1000, 8'd42, 1'b0, 4, "after tmo");
        Req = '0;
        step();

        // reset in the middle of WAIT
        Req = 4'b0001;
        ReqMultiplicand = 16'h0005;
        ReqMultiplier = 16'h0005;
        step();
        step();
        Reset = 1'b1;
        step();
        chk(32'(Grant), 0, "midrst grant");
        chk(32'(Done), 0, "midrst done");
        chk(32'(Result), 0, "midrst result");
        chk(32'(Error), 0, "midrst error");
        chk(32'(MulStart), 0, "midrst start");
        chk(32'(MulMultiplicand), 0, "midrst mula");
        Reset = 1'b0;
        Req = '0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Done != '0) seen++;
        end
        chk(seen, 0, "midrst no done");
        Req = 4'b0100;
        ReqMultiplicand = 16'h0900;
        ReqMultiplier = 16'h0300;
        wait_done(4'b0100, 8'd27, 1'b0, 4, "after rst");
        Req = '0;
        step();

        // stale Ready held through ISSUE and first WAIT cycle
        hold_stale = 1'b1;
        lat = 3;
        Req = 4'b0001;
        ReqMultiplicand = 16'h0002;
        ReqMultiplier = 16'h0004;
        wait_done(4'b0001, 8'd8, 1'b0, 6, "stale");
        Req = '0;
        hold_stale = 1'b0;
        lat = 1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
